ex_unit: RTL and testbench
==========================

# ex_unit

Execute stage for the five-stage MIPS pipeline. It sits between the decode stage and the memory stage and registers the decode outputs at its ID/EX boundary. It performs logic and shift operations, then registers the result toward the memory stage. Decode receives forwarding data from it. Shifts are iterative (one bit per cycle) by default, and the block stalls the front end while a shift is in progress.

## Interface
Parameters:
- none. Widths come from the shared bus defines: RegBus 32, RegAddrBus 5, AluOpBus 8, AluSelBus 3.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous and active-high (`RstEnable`).
- aluop_i  in  8  operation subtype from decode (`EXE_OR_OP`, `EXE_AND_OP`, `EXE_XOR_OP`, `EXE_NOR_OP`, `EXE_SLL_OP`, `EXE_SRL_OP`, `EXE_SRA_OP`, `EXE_NOP_OP`).
- alusel_i  in  3  result class (`EXE_RES_LOGIC`, `EXE_RES_SHIFT`, `EXE_RES_NOP`).
- reg1_i  in  32  operand 1. For shifts, bits [4:0] hold the shift amount.
- reg2_i  in  32  operand 2. For shifts, this is the value to be shifted.
- wd_i  in  5  destination register.
- wreg_i  in  1  write enable for the destination register.
- stallreq_o  out  1  stall request. While high, decode/IF must hold their outputs.
- fwd_wreg_o  out  1  forwarding: the instruction in EX writes a register and its result is ready.
- fwd_wd_o  out  5  forwarding destination.
- fwd_wdata_o  out  32  forwarding data.
- mem_wreg_o  out  1  registered write enable to the memory stage.
- mem_wd_o  out  5  registered destination to the memory stage.
- mem_wdata_o  out  32  registered result to the memory stage.

## Operation
- ID/EX register: captures aluop/alusel/reg1/reg2/wd/wreg on each edge where stallreq_o = 0. It holds its value while stallreq_o = 1.
- Logic class: the result is available combinationally in the cycle after capture.
  - OR: reg1|reg2.
  - AND: reg1&reg2.
  - XOR: reg1^reg2.
  - NOR: ~(reg1|reg2).
- Shift class: amount is reg1[4:0].
  - SLL: logical left shift.
  - SRL: logical right shift.
  - SRA: arithmetic right shift; vacated bits are filled with reg2[31].
- Iterative shifter (default build): a two-state FSM, IDLE and SHIFT.
  - On capture of a shift with amount k > 0: load acc = reg2 and cnt = k, then enter SHIFT.
  - In SHIFT: each cycle, shift acc by one bit and decrement cnt. When cnt reaches 0, return to IDLE.
  - If k = 0: stay in IDLE; the result is reg2.
  - stallreq_o = (state == SHIFT).
- Unknown aluop, or alusel = NOP: the result is 0, and wreg passes through unchanged.
- Forwarding outputs:
  - fwd_wreg_o = captured wreg && !stallreq_o.
  - fwd_wd_o = captured wd.
  - fwd_wdata_o = current result.
- EX/MEM register:
  - When stallreq_o = 0: capture fwd_wreg/fwd_wd/fwd_wdata.
  - When stallreq_o = 1: load a bubble (mem_wreg_o = 0, mem_wd_o = 0, mem_wdata_o = 0).

## Timing
- Reset values: all registers are cleared.
  - ID/EX contents = NOP with wreg = 0.
  - FSM = IDLE; stallreq_o = 0.
  - fwd_wreg_o = 0, fwd_wd_o = 0, fwd_wdata_o = 0.
  - mem_wreg_o = 0, mem_wd_o = 0, mem_wdata_o = 0.
- Logic op, or shift with k = 0:
  - Presented by decode in cycle N.
  - Forwarded during cycle N+1.
  - Appears on the mem_* outputs after edge N+1.
- Shift with k > 0 (iterative build):
  - stallreq_o is high for exactly k cycles (N+1 through N+k).
  - The result is forwarded in cycle N+k+1 and appears on mem_* after edge N+k+1.
  - The next instruction held by decode is captured at edge N+k+1.
- Reset asserted mid-shift: the FSM is forced to IDLE and the partial result is discarded. Outputs take their reset values on the next edge.
- Back-to-back dependent instructions need no stall beyond the shift stall; forwarding covers the EX→ID path.
- A shift amount of 31 gives the maximum stall of 31 cycles.

## Configuration
- EX_BARREL_SHIFT_EN defined: shifts are computed by a single-cycle barrel shifter. The FSM is not instantiated, stallreq_o is tied 0, and shift latency equals logic latency.
- EX_BARREL_SHIFT_EN undefined (default): the iterative shifter described above is used.

## Test plan
- OR: reg1=0x0000F0F0, reg2=0x12340000, wd=5, wreg=1.
  - fwd_wreg_o=1, fwd_wd_o=5, fwd_wdata_o=0x1234F0F0 in the next cycle.
  - mem_* outputs carry the same values one edge later; stallreq_o stays 0.
- NOR: reg1=0, reg2=0 → mem_wdata_o=0xFFFFFFFF. Also check XOR 0xFF00FF00^0x0F0F0F0F → 0xF00FF00F.
- SRA: reg2=0x80000000, reg1=4, wd=7.
  - Default build: stallreq_o high for 4 cycles; mem_* carries bubbles during those cycles; then mem_wdata_o=0xF8000000 with mem_wd_o=7.
  - With EX_BARREL_SHIFT_EN defined: same result with no stall.
- SLL with amount 0 (reg2=0xDEADBEEF): no stall, result 0xDEADBEEF. Also SRL by 31 of 0xFFFFFFFF: result 0x00000001 after 31 stall cycles.
- SRL by 3, then an AND held by decode: the AND is captured only after stallreq_o falls, and the mem_* results arrive in program order.
- Assert rst during cycle 2 of a 10-bit shift: on the next edge, stallreq_o=0 and mem_wreg_o=0. The FSM returns to IDLE and the pipeline accepts a new instruction after rst deasserts.

Source files
------------

// File: rtl/ex_unit.sv
// ============================================================================
// Module   : ex_unit
// Brief    : MIPS execute stage. It holds the ID/EX and EX/MEM registers and
//            implements the logic and shift operations. It also drives the
//            forwarding path back to decode. Shifts are iterative (one bit per
//            cycle) and stall the front end. Defining EX_BARREL_SHIFT_EN
//            selects a single-cycle barrel shifter with no stall instead.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  output logic        stallreq_o,
  output logic        fwd_wreg_o,
  output logic [4:0]  fwd_wd_o,
  output logic [31:0] fwd_wdata_o,
  output logic        mem_wreg_o,
  output logic [4:0]  mem_wd_o,
  output logic [31:0] mem_wdata_o
);

  localparam logic [7:0] c_EXE_AND_OP = 8'b0010_0100;
  localparam logic [7:0] c_EXE_OR_OP  = 8'b0010_0101;
  localparam logic [7:0] c_EXE_XOR_OP = 8'b0010_0110;
  localparam logic [7:0] c_EXE_NOR_OP = 8'b0010_0111;
  localparam logic [7:0] c_EXE_SLL_OP = 8'b0111_1100;
  localparam logic [7:0] c_EXE_SRL_OP = 8'b0000_0010;
  localparam logic [7:0] c_EXE_SRA_OP = 8'b0000_0011;

  localparam logic [2:0] c_EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] c_EXE_RES_SHIFT = 3'b010;

  logic [7:0]  r_aluop;
  logic [2:0]  r_alusel;
  logic [31:0] r_reg1;
  logic [31:0] r_reg2;
  logic [4:0]  r_wd;
  logic        r_wreg;

  logic        w_stall;
  logic [31:0] w_shift_res;
  logic [31:0] w_result;
  logic        w_is_shift_op;

  // ID/EX register: freezes while a shift is in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      r_aluop  <= 8'd0;
      r_alusel <= 3'd0;
      r_reg1   <= 32'd0;
      r_reg2   <= 32'd0;
      r_wd     <= 5'd0;
      r_wreg   <= 1'b0;
    end else if (!w_stall) begin
      r_aluop  <= aluop_i;
      r_alusel <= alusel_i;
      r_reg1   <= reg1_i;
      r_reg2   <= reg2_i;
      r_wd     <= wd_i;
      r_wreg   <= wreg_i;
    end
  end

  assign w_is_shift_op = (r_aluop == c_EXE_SLL_OP) || (r_aluop == c_EXE_SRL_OP) ||
                         (r_aluop == c_EXE_SRA_OP);

`ifdef EX_BARREL_SHIFT_EN

  assign w_stall = 1'b0;

  // Single-cycle barrel shifter over the captured operands
  always_comb begin
    w_shift_res = 32'd0;
    case (r_aluop)
      c_EXE_SLL_OP: w_shift_res = r_reg2 << r_reg1[4:0];
      c_EXE_SRL_OP: w_shift_res = r_reg2 >> r_reg1[4:0];
      c_EXE_SRA_OP: w_shift_res = $unsigned($signed(r_reg2) >>> r_reg1[4:0]);
      default:      w_shift_res = 32'd0;
    endcase
  end

`else

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_acc;
  logic [31:0] w_acc_nxt;
  logic [4:0]  r_cnt;
  logic [4:0]  w_cnt_nxt;
  logic        w_start;

  // A shift is started from the decode inputs at the same edge that captures it
  assign w_start = (alusel_i == c_EXE_RES_SHIFT) &&
                   ((aluop_i == c_EXE_SLL_OP) || (aluop_i == c_EXE_SRL_OP) ||
                    (aluop_i == c_EXE_SRA_OP));

  // Shifter state, accumulator and remaining-bit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= 32'd0;
      r_cnt   <= 5'd0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: load on capture, then shift one bit per cycle until cnt hits 0
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          // acc is loaded even for k = 0 so that the idle result is always acc
          w_acc_nxt = reg2_i;
          w_cnt_nxt = reg1_i[4:0];
          if (reg1_i[4:0] != 5'd0) begin
            w_state_nxt = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        case (r_aluop)
          c_EXE_SLL_OP: w_acc_nxt = {r_acc[30:0], 1'b0};
          c_EXE_SRL_OP: w_acc_nxt = {1'b0, r_acc[31:1]};
          c_EXE_SRA_OP: w_acc_nxt = {r_acc[31], r_acc[31:1]};
          default:      w_acc_nxt = r_acc;
        endcase
        w_cnt_nxt = r_cnt - 5'd1;
        if (r_cnt == 5'd1) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_stall     = (r_state == S_SHIFT);
  assign w_shift_res = r_acc;

`endif

  // Result mux: unknown operations and the NOP class yield zero
  always_comb begin
    w_result = 32'd0;
    case (r_alusel)
      c_EXE_RES_LOGIC: begin
        case (r_aluop)
          c_EXE_OR_OP:  w_result = r_reg1 | r_reg2;
          c_EXE_AND_OP: w_result = r_reg1 & r_reg2;
          c_EXE_XOR_OP: w_result = r_reg1 ^ r_reg2;
          c_EXE_NOR_OP: w_result = ~(r_reg1 | r_reg2);
          default:      w_result = 32'd0;
        endcase
      end
      c_EXE_RES_SHIFT: begin
        if (w_is_shift_op) begin
          w_result = w_shift_res;
        end
      end
      default: w_result = 32'd0;
    endcase
  end

  assign stallreq_o  = w_stall;
  assign fwd_wreg_o  = r_wreg && !w_stall;
  assign fwd_wd_o    = r_wd;
  assign fwd_wdata_o = w_result;

  // EX/MEM register: a bubble goes downstream while the shifter is busy
  always_ff @(posedge clk) begin
    if (rst || w_stall) begin
      mem_wreg_o  <= 1'b0;
      mem_wd_o    <= 5'd0;
      mem_wdata_o <= 32'd0;
    end else begin
      mem_wreg_o  <= fwd_wreg_o;
      mem_wd_o    <= fwd_wd_o;
      mem_wdata_o <= fwd_wdata_o;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ex_unit.sv
// ============================================================================
// Module   : tb_ex_unit
// Brief    : Directed self-checking bench for ex_unit. Expectations follow
//            EX_BARREL_SHIFT_EN in the same way as the design does.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_unit;

  localparam logic [7:0] c_AND = 8'b0010_0100;
  localparam logic [7:0] c_OR  = 8'b0010_0101;
  localparam logic [7:0] c_XOR = 8'b0010_0110;
  localparam logic [7:0] c_NOR = 8'b0010_0111;
  localparam logic [7:0] c_SLL = 8'b0111_1100;
  localparam logic [7:0] c_SRL = 8'b0000_0010;
  localparam logic [7:0] c_SRA = 8'b0000_0011;
  localparam logic [7:0] c_NOP = 8'b0000_0000;

  localparam logic [2:0] c_RES_NOP   = 3'b000;
  localparam logic [2:0] c_RES_LOGIC = 3'b001;
  localparam logic [2:0] c_RES_SHIFT = 3'b010;

`ifdef EX_BARREL_SHIFT_EN
  localparam bit c_BARREL = 1'b1;
`else
  localparam bit c_BARREL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic        stallreq_o;
  logic        fwd_wreg_o;
  logic [4:0]  fwd_wd_o;
  logic [31:0] fwd_wdata_o;
  logic        mem_wreg_o;
  logic [4:0]  mem_wd_o;
  logic [31:0] mem_wdata_o;

  int checks = 0;
  int errors = 0;

  ex_unit dut (
    .clk         (clk),
    .rst         (rst),
    .aluop_i     (aluop_i),
    .alusel_i    (alusel_i),
    .reg1_i      (reg1_i),
    .reg2_i      (reg2_i),
    .wd_i        (wd_i),
    .wreg_i      (wreg_i),
    .stallreq_o  (stallreq_o),
    .fwd_wreg_o  (fwd_wreg_o),
    .fwd_wd_o    (fwd_wd_o),
    .fwd_wdata_o (fwd_wdata_o),
    .mem_wreg_o  (mem_wreg_o),
    .mem_wd_o    (mem_wd_o),
    .mem_wdata_o (mem_wdata_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [4:0] wd, input logic wr);
    aluop_i  = op;
    alusel_i = sel;
    reg1_i   = r1;
    reg2_i   = r2;
    wd_i     = wd;
    wreg_i   = wr;
  endtask

  task automatic drive_nop();
    drive(c_NOP, c_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
  endtask

  // Issue one instruction followed by NOPs and check the stall window, forwarding and mem.
  // Every check here runs at a negedge.
  task automatic run_op(input string tag, input logic [7:0] op, input logic [2:0] sel,
                        input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] wd,
                        input logic wr, input int stall_cycles, input logic [31:0] exp);
    drive(op, sel, r1, r2, wd, wr);
    @(negedge clk);
    drive_nop();
    for (int i = 0; i < stall_cycles; i++) begin
      chk({tag, "_stall"}, {31'd0, stallreq_o}, 32'd1);
      chk({tag, "_bubble_wreg"}, {31'd0, mem_wreg_o}, 32'd0);
      chk({tag, "_bubble_wdata"}, mem_wdata_o, 32'd0);
      @(negedge clk);
    end
    chk({tag, "_nostall"}, {31'd0, stallreq_o}, 32'd0);
    chk({tag, "_fwd_wreg"}, {31'd0, fwd_wreg_o}, {31'd0, wr});
    chk({tag, "_fwd_wd"}, {27'd0, fwd_wd_o}, {27'd0, wd});
    chk({tag, "_fwd_wdata"}, fwd_wdata_o, exp);
    @(negedge clk);
    chk({tag, "_mem_wreg"}, {31'd0, mem_wreg_o}, {31'd0, wr});
    chk({tag, "_mem_wd"}, {27'd0, mem_wd_o}, {27'd0, wd});
    chk({tag, "_mem_wdata"}, mem_wdata_o, exp);
    chk({tag, "_mem_stall"}, {31'd0, stallreq_o}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive_nop();
    @(negedge clk);
    @(negedge clk);
    chk("rst_stall", {31'd0, stallreq_o}, 32'd0);
    chk("rst_fwd_wreg", {31'd0, fwd_wreg_o}, 32'd0);
    chk("rst_fwd_wd", {27'd0, fwd_wd_o}, 32'd0);
    chk("rst_fwd_wdata", fwd_wdata_o, 32'd0);
    chk("rst_mem_wreg", {31'd0, mem_wreg_o}, 32'd0);
    chk("rst_mem_wd", {27'd0, mem_wd_o}, 32'd0);
    chk("rst_mem_wdata", mem_wdata_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Logic class
    run_op("or",  c_OR,  c_RES_LOGIC, 32'h0000F0F0, 32'h12340000, 5'd5, 1'b1, 0, 32'h1234F0F0);
    run_op("nor", c_NOR, c_RES_LOGIC, 32'h00000000, 32'h00000000, 5'd6, 1'b1, 0, 32'hFFFFFFFF);
    run_op("xor", c_XOR, c_RES_LOGIC, 32'hFF00FF00, 32'h0F0F0F0F, 5'd8, 1'b1, 0, 32'hF00FF00F);
    run_op("and", c_AND, c_RES_LOGIC, 32'hFF00FF00, 32'h0FF00FF0, 5'd4, 1'b1, 0, 32'h0F000F00);
    run_op("badop", 8'hFF, c_RES_LOGIC, 32'hFFFFFFFF, 32'h12345678, 5'd11, 1'b1, 0, 32'h0);
    run_op("nopcls", c_OR, c_RES_NOP, 32'hFFFFFFFF, 32'h12345678, 5'd12, 1'b1, 0, 32'h0);

    // Shift class
    run_op("sra4", c_SRA, c_RES_SHIFT, 32'd4, 32'h80000000, 5'd7, 1'b1,
           c_BARREL ? 0 : 4, 32'hF8000000);
    run_op("sll0", c_SLL, c_RES_SHIFT, 32'd0, 32'hDEADBEEF, 5'd9, 1'b1, 0, 32'hDEADBEEF);
    run_op("sll5", c_SLL, c_RES_SHIFT, 32'd5, 32'h0000000F, 5'd10, 1'b1,
           c_BARREL ? 0 : 5, 32'h000001E0);
    run_op("srl31", c_SRL, c_RES_SHIFT, 32'd31, 32'hFFFFFFFF, 5'd13, 1'b1,
           c_BARREL ? 0 : 31, 32'h00000001);

    // SRL by 3, then an AND held by decode until the stall falls
    drive(c_SRL, c_RES_SHIFT, 32'd3, 32'h80000000, 5'd2, 1'b1);
    @(negedge clk);
    drive(c_AND, c_RES_LOGIC, 32'hFF00FF00, 32'h0FF00FF0, 5'd3, 1'b1);
    for (int i = 0; i < (c_BARREL ? 0 : 3); i++) begin
      chk("hold_stall", {31'd0, stallreq_o}, 32'd1);
      chk("hold_fwd_wd", {27'd0, fwd_wd_o}, 32'd2);
      chk("hold_fwd_wreg", {31'd0, fwd_wreg_o}, 32'd0);
      @(negedge clk);
    end
    chk("hold_srl_stall", {31'd0, stallreq_o}, 32'd0);
    chk("hold_srl_fwd_wd", {27'd0, fwd_wd_o}, 32'd2);
    chk("hold_srl_fwd_wdata", fwd_wdata_o, 32'h10000000);
    @(negedge clk);
    drive_nop();
    chk("order_mem1_wd", {27'd0, mem_wd_o}, 32'd2);
    chk("order_mem1_wdata", mem_wdata_o, 32'h10000000);
    chk("order_fwd_and_wd", {27'd0, fwd_wd_o}, 32'd3);
    chk("order_fwd_and_wdata", fwd_wdata_o, 32'h0F000F00);
    @(negedge clk);
    chk("order_mem2_wreg", {31'd0, mem_wreg_o}, 32'd1);
    chk("order_mem2_wd", {27'd0, mem_wd_o}, 32'd3);
    chk("order_mem2_wdata", mem_wdata_o, 32'h0F000F00);

    // Reset in cycle 2 of a 10-bit shift
    drive(c_SLL, c_RES_SHIFT, 32'd10, 32'h00000001, 5'd9, 1'b1);
    @(negedge clk);
    drive_nop();
    if (!c_BARREL) chk("mid_stall_pre", {31'd0, stallreq_o}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_stall", {31'd0, stallreq_o}, 32'd0);
    chk("mid_rst_mem_wreg", {31'd0, mem_wreg_o}, 32'd0);
    chk("mid_rst_fwd_wreg", {31'd0, fwd_wreg_o}, 32'd0);
    chk("mid_rst_fwd_wdata", fwd_wdata_o, 32'd0);
    run_op("post_rst_or", c_OR, c_RES_LOGIC, 32'h000000A0, 32'h0000000B, 5'd14, 1'b1, 0,
           32'h000000AB);
    run_op("post_rst_srl", c_SRL, c_RES_SHIFT, 32'd2, 32'h00000010, 5'd15, 1'b1,
           c_BARREL ? 0 : 2, 32'h00000004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
